// File: rtl/rom_port_arbiter.sv
`timescale 1ns/1ps
// Two-requester arbiter for a shared image ROM, with a {valid,id} tag pipeline matching the ROM read latency.
// Define ROM_BURST_LOCK_EN to keep the owner for up to BURST beats; otherwise contention alternates per beat.
module rom_port_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 64,
  parameter int RD_LAT = 1,
  parameter int BURST  = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic          full0,
  input  logic          full1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          vld0,
  output logic          vld1,
  output logic [DW-1:0] rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  tag_t          tag_q [RD_LAT];
  tag_t          tag_in;
  logic          elig0, elig1;
  logic          lock;
  logic          pick1;

  assign elig0 = req0 & ~full0;
  assign elig1 = req1 & ~full1;

`ifdef ROM_BURST_LOCK_EN
  logic [3:0] cnt_q, cnt_d;
  logic       owner_gnt, owner_elig;

  // Counts beats granted to the current owner; zero means the burst is spent or never started.
  always_comb begin
    owner_gnt  = ((state_q == OWN0) && gnt0) || ((state_q == OWN1) && gnt1);
    owner_elig = ((state_q == OWN0) && elig0) || ((state_q == OWN1) && elig1);
    cnt_d      = cnt_q;
    if (gnt0 || gnt1) begin
      if (owner_gnt) cnt_d = (cnt_q == 4'(BURST - 1)) ? 4'd0 : cnt_q + 4'd1;
      else           cnt_d = (BURST == 1) ? 4'd0 : 4'd1;
    end else if (!owner_elig) begin
      cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= 4'd0;
    else          cnt_q <= cnt_d;
  end

  assign lock = (state_q != IDLE) && (cnt_q != 4'd0);
`else
  assign lock = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no path leaves a latch behind.
  always_comb begin
    pick1 = lock ? (state_q == OWN1) : (state_q == OWN0);
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (reset_n) begin
      if (elig0 && elig1) begin
        gnt0 = ~pick1;
        gnt1 = pick1;
      end else begin
        gnt0 = elig0;
        gnt1 = elig1;
      end
    end

    rom_addr = addr_q;
    if (gnt0)      rom_addr = addr0;
    else if (gnt1) rom_addr = addr1;

    state_d = state_q;
    if (gnt0)      state_d = OWN0;
    else if (gnt1) state_d = OWN1;

    tag_in.valid = gnt0 | gnt1;
    tag_in.id    = gnt1;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= rom_addr;
    end
  end

  // NOTE: the tag pipeline is reset so beats in flight at reset never produce a vld.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign vld0  = tag_q[RD_LAT-1].valid & ~tag_q[RD_LAT-1].id;
  assign vld1  = tag_q[RD_LAT-1].valid &  tag_q[RD_LAT-1].id;
  assign rdata = rom_data;

endmodule

// File: tb/tb_rom_port_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for rom_port_arbiter: two instances (RD_LAT 1 and 3) share stimulus and are
// compared against a grant-history reference model; honours ROM_BURST_LOCK_EN when defined.
module tb_rom_port_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 64;
  localparam int BURST = 9;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0, req1, full0, full1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] rom_data;

  logic          gnt0_a, gnt1_a, vld0_a, vld1_a;
  logic [AW-1:0] rom_addr_a;
  logic [DW-1:0] rdata_a;
  logic          gnt0_b, gnt1_b, vld0_b, vld1_b;
  logic [AW-1:0] rom_addr_b;
  logic [DW-1:0] rdata_b;

  always #5 clk = ~clk;

  rom_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .BURST(BURST)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .full0(full0), .full1(full1), .gnt0(gnt0_a), .gnt1(gnt1_a), .rom_addr(rom_addr_a),
    .rom_data(rom_data), .vld0(vld0_a), .vld1(vld1_a), .rdata(rdata_a));

  rom_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .BURST(BURST)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .full0(full0), .full1(full1), .gnt0(gnt0_b), .gnt1(gnt1_b), .rom_addr(rom_addr_b),
    .rom_data(rom_data), .vld0(vld0_b), .vld1(vld1_b), .rdata(rdata_b));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who was granted last, how long the current run is, and the last three grants.
  int            m_last, m_run, h1, h2, h3;
  logic [AW-1:0] m_addr;

  // Values sampled by the most recent step, for sequence-specific checks.
  logic s_gnt0, s_gnt1, s_vld0_a, s_vld0_b, s_vld1_b;

  typedef struct {
    logic          req0, req1, full0, full1;
    logic [AW-1:0] addr0, addr1;
    logic          exp_gnt0, exp_gnt1;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_last = -1;
    m_run  = 0;
    m_addr = '0;
    h1 = -1; h2 = -1; h3 = -1;
  endtask

  function automatic int model_pick();
    logic e0, e1;
    e0 = req0 && !full0;
    e1 = req1 && !full1;
    if (!reset_n) return -1;
    if (e0 && e1) begin
`ifdef ROM_BURST_LOCK_EN
      if (m_last >= 0 && (m_run % BURST) != 0) return m_last;
`endif
      return (m_last == 0) ? 1 : 0;
    end
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  // One clock cycle: sample at the falling edge, compare, advance the model, move past the rising edge.
  task automatic step();
    int            pick;
    logic [AW-1:0] exp_addr;
    logic          own_elig;
    @(negedge clk);
    if (!reset_n) model_reset();
    pick     = model_pick();
    exp_addr = (pick == 0) ? addr0 : (pick == 1) ? addr1 : m_addr;
    s_gnt0 = gnt0_a; s_gnt1 = gnt1_a;
    s_vld0_a = vld0_a; s_vld0_b = vld0_b; s_vld1_b = vld1_b;

    check("gnt0_lat1", gnt0_a, pick == 0);
    check("gnt1_lat1", gnt1_a, pick == 1);
    check("gnt0_lat3", gnt0_b, pick == 0);
    check("gnt1_lat3", gnt1_b, pick == 1);
    check("rom_addr_lat1", rom_addr_a, exp_addr);
    check("rom_addr_lat3", rom_addr_b, exp_addr);
    check("vld0_lat1", vld0_a, h1 == 0);
    check("vld1_lat1", vld1_a, h1 == 1);
    check("vld0_lat3", vld0_b, h3 == 0);
    check("vld1_lat3", vld1_b, h3 == 1);
    check("rdata_lat1", rdata_a, rom_data);
    check("rdata_lat3", rdata_b, rom_data);

    own_elig = (m_last == 0 && req0 && !full0) || (m_last == 1 && req1 && !full1);
    if (pick >= 0) begin
      m_run  = (pick == m_last) ? m_run + 1 : 1;
      m_last = pick;
      m_addr = exp_addr;
    end else if (!own_elig) begin
      m_run = 0;
    end
    h3 = h2; h2 = h1; h1 = pick;

    @(posedge clk);
    #1;
    rom_data = {$urandom, $urandom};
  endtask

  task automatic drive(input logic r0, input logic r1, input logic f0, input logic f1,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    req0 = r0; req1 = r1; full0 = f0; full1 = f1; addr0 = a0; addr1 = a1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, '0, '0);
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    rom_data = '0;
    drive(0, 0, 0, 0, '0, '0);
    model_reset();

    // req0 stream, idle hold, blocked and unblocked requester 1, requester 0 blocked by full0.
    vecs[0] = '{1, 0, 0, 0, 16'd100, 16'd0, 1, 0, 16'd100};
    vecs[1] = '{1, 0, 0, 0, 16'd101, 16'd0, 1, 0, 16'd101};
    vecs[2] = '{1, 0, 0, 0, 16'd102, 16'd0, 1, 0, 16'd102};
    vecs[3] = '{0, 0, 0, 0, 16'd555, 16'd0, 0, 0, 16'd102};
    vecs[4] = '{0, 1, 0, 1, 16'd0,   16'd7, 0, 0, 16'd102};
    vecs[5] = '{0, 1, 0, 0, 16'd0,   16'd7, 0, 1, 16'd7};
    vecs[6] = '{1, 1, 1, 0, 16'd9,   16'd8, 0, 1, 16'd8};
    vecs[7] = '{0, 0, 0, 0, 16'd0,   16'd0, 0, 0, 16'd8};

    // Reset state: outputs quiet even with requests asserted.
    drive(1, 1, 0, 0, 16'h1234, 16'h5678);
    @(negedge clk);
    check("reset_gnt0", gnt0_a, 1'b0);
    check("reset_gnt1", gnt1_a, 1'b0);
    check("reset_rom_addr", rom_addr_a, 16'h0);
    check("reset_vld0", vld0_b, 1'b0);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].req0, vecs[i].req1, vecs[i].full0, vecs[i].full1, vecs[i].addr0, vecs[i].addr1);
      step();
      check($sformatf("vec%0d_gnt0", i), s_gnt0, vecs[i].exp_gnt0);
      check($sformatf("vec%0d_gnt1", i), s_gnt1, vecs[i].exp_gnt1);
      check($sformatf("vec%0d_vld0", i), s_vld0_a, (i > 0) ? vecs[i-1].exp_gnt0 : 1'b0);
    end

    // Contention from IDLE for 20 cycles.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      int exp_id;
`ifdef ROM_BURST_LOCK_EN
      exp_id = (i < BURST) ? 0 : (i < 2 * BURST) ? 1 : 0;
`else
      exp_id = i % 2;
`endif
      drive(1, 1, 0, 0, 16'h1000 + AW'(i), 16'h2000 + AW'(i));
      step();
      check($sformatf("contend%0d_gnt0", i), s_gnt0, exp_id == 0);
      check($sformatf("contend%0d_gnt1", i), s_gnt1, exp_id == 1);
    end

    // Backpressure on requester 0 during cycles 3 and 4.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, (i == 3 || i == 4), 0, 16'h0300 + AW'(i), 16'h0);
      step();
      check($sformatf("bp%0d_gnt0", i), s_gnt0, !(i == 3 || i == 4));
      if (i == 3) check("bp_inflight_vld0_lat1", s_vld0_a, 1'b1);
      if (i == 5) check("bp_inflight_vld0_lat3", s_vld0_b, 1'b1);
      if (i == 6) check("bp_gap_vld0_lat3", s_vld0_b, 1'b0);
    end

    // Reset with three beats in flight in the latency-3 instance.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 16'h0a00 + AW'(i), 16'h0);
      step();
    end
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_mid_vld0_lat3", s_vld0_b, 1'b0);
      check("rst_mid_gnt0", s_gnt0, 1'b0);
    end
    reset_n = 1'b1;
    drive(1, 1, 0, 0, 16'h0b00, 16'h0c00);
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) begin
        check("post_rst_gnt0", s_gnt0, 1'b1);
        check("post_rst_gnt1", s_gnt1, 1'b0);
      end
      check("post_rst_vld0_lat3", s_vld0_b, 1'b0);
      check("post_rst_vld1_lat3", s_vld1_b, 1'b0);
    end

    // Randomised traffic, long contention stretches, occasional reset.
    for (int i = 0; i < 600; i++) begin
      logic bias;
      bias = (i / 40) % 2 == 1;
      reset_n = ($urandom_range(0, 149) != 0);
      drive(bias ? 1'b1 : ($urandom_range(0, 3) != 0),
            bias ? 1'b1 : ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
            AW'($urandom), AW'($urandom));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
